// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812B frame fetch path.
package ws2812_pkg;

  localparam int PIX_W   = 24;
  localparam int SRAM_AW = 17;

  localparam logic [1:0] BYTE_G = 2'd0;
  localparam logic [1:0] BYTE_R = 2'd1;
  localparam logic [1:0] BYTE_B = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/pixel_out_reg.sv
// Single-entry valid/ready holding register between the fetch FSM and the LED serialiser.
module pixel_out_reg
  import ws2812_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [PIX_W-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [PIX_W-1:0] data_o,
  output logic             free_o,
  output logic             accept_o
);

  logic             valid_q, valid_d;
  logic [PIX_W-1:0] data_q, data_d;

  assign accept_o = valid_q && ready_i;
  // Free when empty or being drained at this edge, so load and accept may coincide.
  assign free_o   = !valid_q || ready_i;
  assign valid_o  = valid_q;
  assign data_o   = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (accept_o) valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/ws2812_frame_reader.sv
// Walks a frame of GRB byte triplets in SRAM and hands assembled pixels to the serialiser.
module ws2812_frame_reader
  import ws2812_pkg::*;
#(
  parameter int                 NUM_LEDS  = 64,
  parameter logic [SRAM_AW-1:0] BASE_ADDR = 17'h00000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               frame_done,
  output logic [SRAM_AW-1:0] r_address,
  output logic               r_request,
  input  logic               r_done,
  input  logic [7:0]         r_data,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_valid,
  input  logic               pix_ready
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_LEDS - 1);

  state_e             state_q, state_d;
  logic [15:0]        pix_idx_q, pix_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]   asm_q, asm_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               last_loaded_q, last_loaded_d;

  logic out_load, out_free, out_accept;

  pixel_out_reg u_out (
    .clk_i    (clk),
    .rst_i    (reset),
    .load_i   (out_load),
    .data_i   (asm_q),
    .ready_i  (pix_ready),
    .valid_o  (pix_valid),
    .data_o   (pix_data),
    .free_o   (out_free),
    .accept_o (out_accept)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign r_address  = addr_q;
  assign r_request  = (state_q == ST_REQ);

  always_comb begin
    state_d       = state_q;
    pix_idx_d     = pix_idx_q;
    byte_idx_d    = byte_idx_q;
    addr_d        = addr_q;
    asm_d         = asm_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    last_loaded_d = last_loaded_q;
    out_load      = 1'b0;

    if (out_accept && last_loaded_q) begin
      busy_d        = 1'b0;
      frame_done_d  = 1'b1;
      last_loaded_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // frame_done_q gate drops a start that lands in the frame_done cycle
        if (start && !busy_q && !frame_done_q) begin
          busy_d     = 1'b1;
          pix_idx_d  = '0;
          byte_idx_d = BYTE_G;
          addr_d     = BASE_ADDR;
          asm_d      = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (r_done) begin
          case (byte_idx_q)
            BYTE_G:  asm_d[23:16] = r_data;
            BYTE_R:  asm_d[15:8]  = r_data;
            default: asm_d[7:0]   = r_data;
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
          addr_d     = addr_q + 17'd1;
          state_d    = ST_GAP;
        end
      end
      ST_GAP, ST_HOLD: begin
        if (state_q == ST_GAP && byte_idx_q <= BYTE_B) begin
          state_d = ST_REQ;
        end else if (out_free) begin
          out_load = 1'b1;
          if (pix_idx_q == LAST_IDX) begin
            last_loaded_d = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            pix_idx_d  = pix_idx_q + 16'd1;
            byte_idx_d = BYTE_G;
            state_d    = ST_REQ;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pix_idx_q     <= '0;
      byte_idx_q    <= BYTE_G;
      addr_q        <= '0;
      asm_q         <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      last_loaded_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_idx_q     <= pix_idx_d;
      byte_idx_q    <= byte_idx_d;
      addr_q        <= addr_d;
      asm_q         <= asm_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      last_loaded_q <= last_loaded_d;
    end
  end

endmodule
